// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: operand-forward
// select encodings, FSM state type and default parameter values.
package pipeline_hazard_ctrl_pkg;

  // EX operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from the EX/MEM buffer
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from the MEM/WB buffer

  // Controller FSM states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_BUSY = 1'b1
  } hz_state_t;

  // Default widths and depths
  localparam int DEF_RA_W     = 4;
  localparam int DEF_NFLUSH   = 2;
  localparam int DEF_MC_LAT   = 4;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hz_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module hz_sat_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count events, holding at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall / flush / forward control for a 5-stage IF-ID-EX-MEM-WB
// pipeline. Forward selects are computed from the ID-stage sources and
// registered so they are stable for the instruction when it reaches EX.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W     = DEF_RA_W,
  parameter int NFLUSH   = DEF_NFLUSH,
  parameter int MC_LAT   = DEF_MC_LAT,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra_id,
  input  logic [RA_W-1:0]   rb_id,
  input  logic              ra_use_id,
  input  logic              rb_use_id,
  input  logic [RA_W-1:0]   rd_ex,
  input  logic              regwrite_ex,
  input  logic              memtoreg_ex,
  input  logic [RA_W-1:0]   rd_mem,
  input  logic              regwrite_mem,
  input  logic              mc_start_ex,
  input  logic              branch_taken_ex,
  output logic              stall_front,
  output logic              stall_ex,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic [NFLUSH-1:0] flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MC_CW = $clog2(MC_LAT + 1);

  hz_state_t        state_reg, state_next;
  logic [MC_CW-1:0] mc_cnt_reg, mc_cnt_next;
  logic [1:0]       fwd_a_reg, fwd_b_reg;
  logic [1:0]       fwd_a_next, fwd_b_next;

  logic a_ex_hit, b_ex_hit, a_mem_hit, b_mem_hit;
  logic load_use;
  logic flush_all;
  logic fwd_clr;

  // A source matches a producer when it is really read, the producer really
  // writes, and the indices agree; optionally index 0 is hard-wired.
  function automatic logic src_hit(input logic [RA_W-1:0] src,
                                   input logic            use_src,
                                   input logic [RA_W-1:0] rd,
                                   input logic            wr);
    logic zero_blocked;
    zero_blocked = (ZERO_REG != 0) && (src == '0);
    return use_src && wr && (src == rd) && !zero_blocked;
  endfunction

  // Producer matches and the next forward selects (EX producer has priority;
  // a load in EX never forwards from MEM because the interlock covers it)
  always_comb begin
    a_ex_hit  = src_hit(ra_id, ra_use_id, rd_ex,  regwrite_ex);
    b_ex_hit  = src_hit(rb_id, rb_use_id, rd_ex,  regwrite_ex);
    a_mem_hit = src_hit(ra_id, ra_use_id, rd_mem, regwrite_mem);
    b_mem_hit = src_hit(rb_id, rb_use_id, rd_mem, regwrite_mem);
    load_use  = memtoreg_ex && (a_ex_hit || b_ex_hit);

    fwd_a_next = FWD_RF;
    if (a_ex_hit && !memtoreg_ex) begin
      fwd_a_next = FWD_MEM;
    end else if (a_mem_hit) begin
      fwd_a_next = FWD_WB;
    end

    fwd_b_next = FWD_RF;
    if (b_ex_hit && !memtoreg_ex) begin
      fwd_b_next = FWD_MEM;
    end else if (b_mem_hit) begin
      fwd_b_next = FWD_WB;
    end
  end

  // FSM state and multi-cycle occupancy counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      mc_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  // Next state and control outputs; branch beats multi-cycle beats load-use.
  // The start cycle is itself a stall cycle, so MC_BUSY lasts MC_LAT-2 cycles
  // and the counter reaches 1 on the edge that returns to IDLE.
  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    stall_front = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    bubble_mem  = 1'b0;
    flush_all   = 1'b0;
    mc_busy     = 1'b0;
    if (rst) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (branch_taken_ex) begin
            flush_all = 1'b1;
          end else if (mc_start_ex) begin
            stall_front = 1'b1;
            stall_ex    = 1'b1;
            bubble_mem  = 1'b1;
            mc_cnt_next = MC_CW'(MC_LAT - 1);
            state_next  = (MC_LAT > 2) ? ST_MC_BUSY : ST_IDLE;
          end else if (load_use) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          mc_busy     = 1'b1;
          stall_front = 1'b1;
          stall_ex    = 1'b1;
          bubble_mem  = 1'b1;
          mc_cnt_next = mc_cnt_reg - MC_CW'(1);
          if (mc_cnt_reg <= MC_CW'(2)) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Fan the branch flush out to the configured number of younger buffers
  genvar gi;
  generate
    for (gi = 0; gi < NFLUSH; gi++) begin : g_flush
      assign flush[gi] = flush_all;
    end
  endgenerate

  // Clearing the ID/EX buffer also invalidates the forward selects
  generate
    if (NFLUSH > 1) begin : g_fwd_clr_flush
      assign fwd_clr = bubble_ex || flush_all;
    end else begin : g_fwd_clr_bubble
      assign fwd_clr = bubble_ex;
    end
  endgenerate

  // Registered forward selects: clear on bubble/flush, hold while EX is held
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (fwd_clr) begin
      fwd_a_reg <= FWD_RF;
      fwd_b_reg <= FWD_RF;
    end else if (!stall_ex) begin
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
    end
  end

  assign fwd_a = fwd_a_reg;
  assign fwd_b = fwd_b_reg;

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_front),
    .clear (1'b0),
    .count (stall_cnt)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_all),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with default
// parameters (RA_W=4, NFLUSH=2, MC_LAT=4, ZERO_REG=1, CNT_W=16).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ra_id, rb_id, rd_ex, rd_mem;
  logic        ra_use_id, rb_use_id, regwrite_ex, memtoreg_ex, regwrite_mem;
  logic        mc_start_ex, branch_taken_ex;
  logic        stall_front, stall_ex, bubble_ex, bubble_mem, mc_busy;
  logic [1:0]  flush, fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ra_id           (ra_id),
    .rb_id           (rb_id),
    .ra_use_id       (ra_use_id),
    .rb_use_id       (rb_use_id),
    .rd_ex           (rd_ex),
    .regwrite_ex     (regwrite_ex),
    .memtoreg_ex     (memtoreg_ex),
    .rd_mem          (rd_mem),
    .regwrite_mem    (regwrite_mem),
    .mc_start_ex     (mc_start_ex),
    .branch_taken_ex (branch_taken_ex),
    .stall_front     (stall_front),
    .stall_ex        (stall_ex),
    .bubble_ex       (bubble_ex),
    .bubble_mem      (bubble_mem),
    .flush           (flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mc_busy         (mc_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ra, rb, rdx, rdm;
    logic       ua, ub, rwx, ldx, rwm, br;
    logic       sf, bex;     // expected this cycle
    logic [1:0] fl;          // expected this cycle
    logic [1:0] fa, fb;      // expected after the edge
    int         scnt, fcnt;  // expected after the edge
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkv(string nm, int ra, int ua, int rb, int ub,
                               int rdx, int rwx, int ldx, int rdm, int rwm,
                               int br, int sf, int bex, int fl, int fa,
                               int fb, int scnt, int fcnt);
    vec_t v;
    v.name = nm;
    v.ra = 4'(ra); v.ua = 1'(ua); v.rb = 4'(rb); v.ub = 1'(ub);
    v.rdx = 4'(rdx); v.rwx = 1'(rwx); v.ldx = 1'(ldx);
    v.rdm = 4'(rdm); v.rwm = 1'(rwm); v.br = 1'(br);
    v.sf = 1'(sf); v.bex = 1'(bex); v.fl = 2'(fl);
    v.fa = 2'(fa); v.fb = 2'(fb); v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    ra_id = '0; rb_id = '0; ra_use_id = 1'b0; rb_use_id = 1'b0;
    rd_ex = '0; regwrite_ex = 1'b0; memtoreg_ex = 1'b0;
    rd_mem = '0; regwrite_mem = 1'b0;
    mc_start_ex = 1'b0; branch_taken_ex = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ra_id = v.ra; ra_use_id = v.ua; rb_id = v.rb; rb_use_id = v.ub;
    rd_ex = v.rdx; regwrite_ex = v.rwx; memtoreg_ex = v.ldx;
    rd_mem = v.rdm; regwrite_mem = v.rwm;
    mc_start_ex = 1'b0; branch_taken_ex = v.br;
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();

    //                 name           ra ua rb ub rdx rwx ldx rdm rwm br  sf bex fl  fa    fb    sc fc
    vecs[0]  = mkv("alu_ex_fwd",      3, 1, 0, 0, 3,  1,  0,  0,  0,  0,  0, 0,  0, 2'b10, 2'b00, 0, 0);
    vecs[1]  = mkv("alu_mem_fwd",     3, 1, 0, 0, 0,  0,  0,  3,  1,  0,  0, 0,  0, 2'b01, 2'b00, 0, 0);
    vecs[2]  = mkv("ex_beats_mem",    3, 1, 0, 0, 3,  1,  0,  3,  1,  0,  0, 0,  0, 2'b10, 2'b00, 0, 0);
    vecs[3]  = mkv("load_use",        0, 0, 5, 1, 5,  1,  1,  0,  0,  0,  1, 1,  0, 2'b00, 2'b00, 1, 0);
    vecs[4]  = mkv("load_after_bub",  0, 0, 5, 1, 0,  0,  0,  5,  1,  0,  0, 0,  0, 2'b00, 2'b01, 1, 0);
    vecs[5]  = mkv("zero_reg",        0, 1, 0, 0, 0,  1,  1,  0,  1,  0,  0, 0,  0, 2'b00, 2'b00, 1, 0);
    vecs[6]  = mkv("src_unused",      4, 0, 0, 0, 4,  1,  0,  0,  0,  0,  0, 0,  0, 2'b00, 2'b00, 1, 0);
    vecs[7]  = mkv("ex_no_write",     6, 1, 0, 0, 6,  0,  0,  6,  1,  0,  0, 0,  0, 2'b01, 2'b00, 1, 0);
    vecs[8]  = mkv("br_vs_loaduse",   2, 1, 5, 1, 5,  1,  1,  2,  1,  1,  0, 0,  3, 2'b00, 2'b00, 1, 1);
    vecs[9]  = mkv("br_clears_fwd",   7, 1, 0, 0, 7,  1,  0,  0,  0,  1,  0, 0,  3, 2'b00, 2'b00, 1, 2);
    vecs[10] = mkv("both_operands",   1, 1, 2, 1, 1,  1,  0,  2,  1,  0,  0, 0,  0, 2'b10, 2'b01, 1, 2);
    vecs[11] = mkv("load_ex_and_mem", 9, 1, 0, 0, 9,  1,  1,  9,  1,  0,  1, 1,  0, 2'b00, 2'b00, 2, 2);
    vecs[12] = mkv("idle",            0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0, 0,  0, 2'b00, 2'b00, 2, 2);

    // Reset held with random inputs: every output stays zero
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      ra_id = 4'($urandom); rb_id = 4'($urandom);
      ra_use_id = 1'($urandom); rb_use_id = 1'($urandom);
      rd_ex = 4'($urandom); regwrite_ex = 1'($urandom); memtoreg_ex = 1'($urandom);
      rd_mem = 4'($urandom); regwrite_mem = 1'($urandom);
      mc_start_ex = 1'($urandom); branch_taken_ex = 1'($urandom);
      #1;
      chk("reset_ctrl", {26'd0, stall_front, stall_ex, bubble_ex, bubble_mem, flush}, 32'd0);
      @(posedge clk); #1;
      chk("reset_regs", {25'd0, mc_busy, fwd_a, fwd_b, 2'b00}, 32'd0);
      chk("reset_cnts", {stall_cnt, flush_cnt}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, ".stall_front"}, 32'(stall_front), 32'(vecs[i].sf));
      chk({vecs[i].name, ".bubble_ex"},   32'(bubble_ex),   32'(vecs[i].bex));
      chk({vecs[i].name, ".flush"},       32'(flush),       32'(vecs[i].fl));
      chk({vecs[i].name, ".stall_ex"},    32'(stall_ex),    32'd0);
      @(posedge clk); #1;
      chk({vecs[i].name, ".fwd_a"},     32'(fwd_a),     32'(vecs[i].fa));
      chk({vecs[i].name, ".fwd_b"},     32'(fwd_b),     32'(vecs[i].fb));
      chk({vecs[i].name, ".stall_cnt"}, 32'(stall_cnt), 32'(vecs[i].scnt));
      chk({vecs[i].name, ".flush_cnt"}, 32'(flush_cnt), 32'(vecs[i].fcnt));
    end

    // Multi-cycle op: 3 stall cycles, busy in cycles 2-3, branch ignored,
    // forward selects frozen while EX is held
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      zero_inputs();
      ra_id = 4'd3; ra_use_id = 1'b1; rd_ex = 4'd3; regwrite_ex = 1'b1;
      mc_start_ex     = (c == 1);
      branch_taken_ex = (c == 2);
      #1;
      chk($sformatf("mc_c%0d.stall_front", c), 32'(stall_front), 32'(c <= 3));
      chk($sformatf("mc_c%0d.stall_ex", c),    32'(stall_ex),    32'(c <= 3));
      chk($sformatf("mc_c%0d.bubble_mem", c),  32'(bubble_mem),  32'(c <= 3));
      chk($sformatf("mc_c%0d.mc_busy", c),     32'(mc_busy),     32'(c == 2 || c == 3));
      chk($sformatf("mc_c%0d.flush", c),       32'(flush),       32'd0);
      @(posedge clk); #1;
      chk($sformatf("mc_c%0d.fwd_a", c), 32'(fwd_a), (c == 4) ? 32'd2 : 32'd0);
    end
    chk("mc.stall_cnt", 32'(stall_cnt), 32'd5);
    chk("mc.flush_cnt", 32'(flush_cnt), 32'd2);

    // Reset while MC_BUSY aborts the op and clears the counters
    @(negedge clk);
    zero_inputs();
    mc_start_ex = 1'b1;
    @(negedge clk);
    mc_start_ex = 1'b0;
    #1;
    chk("mcrst.busy_before", 32'(mc_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mcrst.mc_busy",     32'(mc_busy),     32'd0);
    chk("mcrst.stall_front", 32'(stall_front), 32'd0);
    chk("mcrst.counters",    {stall_cnt, flush_cnt}, 32'd0);

    // Flush counter saturation
    @(negedge clk);
    force dut.u_flush_cnt.count_reg = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.u_flush_cnt.count_reg;
    branch_taken_ex = 1'b1;
    #1;
    chk("sat.flush", 32'(flush), 32'd3);
    @(posedge clk); #1;
    chk("sat.flush_cnt", 32'(flush_cnt), 32'h0000FFFF);
    @(negedge clk);
    branch_taken_ex = 1'b0;
    @(posedge clk); #1;
    chk("sat.flush_cnt_hold", 32'(flush_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
